// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter_pkg                                                      |
// | Shared state encoding, width defaults and ALU control codes.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_arbiter_pkg;

  localparam int c_data_w = 32;
  localparam int c_aluc_w = 4;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle = 2'd0;
  localparam state_t c_st_exec = 2'd1;
  localparam state_t c_st_resp = 2'd2;

  localparam logic [3:0] c_aluc_add  = 4'd0;
  localparam logic [3:0] c_aluc_and  = 4'd1;
  localparam logic [3:0] c_aluc_or   = 4'd2;
  localparam logic [3:0] c_aluc_xor  = 4'd3;
  localparam logic [3:0] c_aluc_sll  = 4'd4;
  localparam logic [3:0] c_aluc_srl  = 4'd5;
  localparam logic [3:0] c_aluc_sra  = 4'd6;
  localparam logic [3:0] c_aluc_addi = 4'd7;
  localparam logic [3:0] c_aluc_beq  = 4'd13;
  localparam logic [3:0] c_aluc_bne  = 4'd14;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2                                                              |
// | Two-way round-robin arbiter producing a one-hot grant.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_last,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On a tie the requester that did not win last time goes next.
        2'b11:   grant = rr_last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter                                                          |
// | Round-robin sharing of one combinational ALU between two requesters. |
// | Optional grant counters when ALU_ARB_STATS_EN is defined.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int ALUC_W = c_aluc_w
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [ALUC_W-1:0] req0_aluc,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [ALUC_W-1:0] req1_aluc,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [ALUC_W-1:0] alu_aluc,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_z
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  state_t            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ALUC_W-1:0] r_aluc;
  logic              r_id;
  logic              r_rr_last;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_r;
  logic              r_rsp_z;

  logic              w_en;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_gid;

  // A held response frees the ALU on the same edge the consumer takes it.
  assign w_en = (r_state == c_st_idle) || ((r_state == c_st_resp) && rsp_ready);

  rr_arb2 u_rr_arb2 (
    .valid   ({req1_valid, req0_valid}),
    .rr_last (r_rr_last),
    .en      (w_en),
    .grant   (w_grant)
  );

  assign w_accept   = |w_grant;
  assign w_gid      = w_grant[1];
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= c_st_idle;
      r_a         <= '0;
      r_b         <= '0;
      r_aluc      <= '0;
      r_id        <= 1'b0;
      r_rr_last   <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_r     <= '0;
      r_rsp_z     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a       <= w_gid ? req1_a    : req0_a;
        r_b       <= w_gid ? req1_b    : req0_b;
        r_aluc    <= w_gid ? req1_aluc : req0_aluc;
        r_id      <= w_gid;
        r_rr_last <= w_gid;
      end
      case (r_state)
        c_st_idle: begin
          if (w_accept) r_state <= c_st_exec;
        end
        c_st_exec: begin
          r_rsp_r     <= alu_r;
          r_rsp_z     <= alu_z;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= c_st_resp;
        end
        c_st_resp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_accept ? c_st_exec : c_st_idle;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= c_st_idle;
        end
      endcase
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_aluc  = r_aluc;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_r     = r_rsp_r;
  assign rsp_z     = r_rsp_z;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt0 <= 16'd0;
      r_cnt1 <= 16'd0;
    end else begin
      if (w_accept && !w_gid) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_accept &&  w_gid) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_arbiter                                                       |
// | Directed self-checking bench with a behavioural shared ALU.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_arbiter;

  logic        clk;
  logic        resetn;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_aluc;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_aluc;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;
  logic        alu_z;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_z;
  logic [31:0] rsp_r;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int total = 0;
  int bad   = 0;

  alu_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_aluc  (req0_aluc),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_aluc  (req1_aluc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_aluc   (alu_aluc),
    .alu_r      (alu_r),
    .alu_z      (alu_z),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r),
    .rsp_z      (rsp_z)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the shared combinational ALU.
  always_comb begin
    case (alu_aluc)
      4'd0, 4'd7:   alu_r = alu_a + alu_b;
      4'd1:         alu_r = alu_a & alu_b;
      4'd2:         alu_r = alu_a | alu_b;
      4'd3:         alu_r = alu_a ^ alu_b;
      4'd4:         alu_r = alu_b << alu_a[4:0];
      4'd5:         alu_r = alu_b >> alu_a[4:0];
      4'd6:         alu_r = $unsigned($signed(alu_b) >>> alu_a[4:0]);
      4'd13, 4'd14: alu_r = alu_a - alu_b;
      default:      alu_r = 32'd0;
    endcase
    alu_z = (alu_r == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op from requester 0 while the arbiter can accept; returns in EXEC.
  task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_aluc = c;
    #1;
    chk("issue0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_aluc = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_aluc = '0;
    step(); step();
    resetn = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id",    {31'd0, rsp_id},    32'd0);
    chk("rst_rsp_r",     rsp_r,              32'd0);
    chk("rst_rsp_z",     {31'd0, rsp_z},     32'd0);
    chk("rst_alu_a",     alu_a,              32'd0);
    chk("rst_alu_b",     alu_b,              32'd0);
    chk("rst_alu_aluc",  {28'd0, alu_aluc},  32'd0);

    // Both requesters valid continuously: alternating grants, requester 0 first.
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_aluc = 4'd13;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_aluc = 4'd2;
    rsp_ready  = 1'b1;
    #1;
    chk("tie_ready0", {31'd0, req0_ready}, 32'd1);
    chk("tie_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    chk("tie_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("tie_exec_aluc",  {28'd0, alu_aluc},  32'd13);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_valid", {31'd0, rsp_valid}, 32'd1);
      chk("rr_id",    {31'd0, rsp_id},    (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_r",     rsp_r,              (k % 2 == 1) ? 32'd3 : 32'd0);
      chk("rr_z",     {31'd0, rsp_z},     (k % 2 == 1) ? 32'd0 : 32'd1);
      if (k < 3) begin
        step();
        chk("rr_gap_valid", {31'd0, rsp_valid}, 32'd0);
      end
    end

    // Backpressure: response held, pending requester 1 waits.
    req0_valid = 1'b0;
    req1_a = 32'd10; req1_b = 32'd20; req1_aluc = 4'd0;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ready1", {31'd0, req1_ready}, 32'd0);
      chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
      chk("bp_valid",  {31'd0, rsp_valid},  32'd1);
      chk("bp_id",     {31'd0, rsp_id},     32'd1);
      chk("bp_r",      rsp_r,               32'd3);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    chk("bp_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_exec_alu_a", alu_a, 32'd10);
    step();
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_rsp_id",    {31'd0, rsp_id},    32'd1);
    chk("bp_rsp_r",     rsp_r,              32'd30);

    // Single requester 0 add, retiring the previous response on the same edge.
    issue0(32'd5, 32'd3, 4'd0);
    step();
    chk("add_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_id",    {31'd0, rsp_id},    32'd0);
    chk("add_r",     rsp_r,              32'd8);
    chk("add_z",     {31'd0, rsp_z},     32'd0);
    step();
    chk("add_idle_valid", {31'd0, rsp_valid}, 32'd0);

    // Shift: operands visible on the ALU during EXEC.
    issue0(32'd4, 32'd1, 4'd4);
    chk("sll_alu_a",    alu_a,             32'd4);
    chk("sll_alu_b",    alu_b,             32'd1);
    chk("sll_alu_aluc", {28'd0, alu_aluc}, 32'd4);
    step();
    chk("sll_r", rsp_r,          32'd16);
    chk("sll_z", {31'd0, rsp_z}, 32'd0);
    step();

    // Unused control code returns r=0, z=1.
    issue0(32'd9, 32'd9, 4'hF);
    step();
    chk("unused_r", rsp_r,          32'd0);
    chk("unused_z", {31'd0, rsp_z}, 32'd1);
    step();

    // Requester 1 raises then drops valid while the ALU is busy: nothing latched.
    issue0(32'd2, 32'd2, 4'd3);
    req1_valid = 1'b1; req1_a = 32'hDEAD; req1_b = 32'hBEEF; req1_aluc = 4'd1;
    #1;
    chk("drop_ready1", {31'd0, req1_ready}, 32'd0);
    req1_valid = 1'b0;
    step();
    chk("drop_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("drop_rsp_z",  {31'd0, rsp_z},  32'd1);
    step();
    chk("drop_idle_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    chk("drop_idle_valid2", {31'd0, rsp_valid}, 32'd0);
    chk("drop_alu_b",       alu_b,              32'd2);

`ifdef ALU_ARB_STATS_EN
    chk("cnt0", {16'd0, grant_cnt0}, 32'd6);
    chk("cnt1", {16'd0, grant_cnt1}, 32'd3);
`endif

    // Asynchronous reset in EXEC discards the operation.
    issue0(32'd3, 32'd4, 4'd0);
    resetn = 1'b0;
    #1;
    chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("arst_alu_a", alu_a,              32'd0);
`ifdef ALU_ARB_STATS_EN
    chk("arst_cnt0", {16'd0, grant_cnt0}, 32'd0);
`endif
    step();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
